// File: rtl/ddr3_test_pkg.sv
// Shared types and helpers for the DDR3 AXI read-path checker.
// The expected-data rule lives here so every checker derives the pattern identically.
package ddr3_test_pkg;

    localparam int BEAT_ADDR_STEP   = 8;
    localparam int DEF_MEM_DQ_WIDTH = 32;
    localparam int WORDS_PER_BEAT   = DEF_MEM_DQ_WIDTH / 4;
    localparam int CMD_ADDR_W       = 28;

    typedef struct packed {
        logic [CMD_ADDR_W-1:0] addr;
        logic [3:0]            len;
    } rd_cmd_t;

    function automatic logic [31:0] exp_word(input logic [31:0] seed,
                                             input logic [31:0] addr,
                                             input int unsigned k);
        return seed + addr + k;
    endfunction

endpackage

// File: rtl/ddr3_rd_cmd_fifo.sv
// Command queue holding accepted read bursts until their last beat returns.
// Flush empties it in one cycle; the storage array itself is never cleared.
module ddr3_rd_cmd_fifo
    import ddr3_test_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk_i,
    input  logic    rst_ni,
    input  logic    flush_i,
    input  logic    push_i,
    input  rd_cmd_t din_i,
    input  logic    pop_i,
    output rd_cmd_t dout_o,
    output logic    full_o,
    output logic    empty_o
);
    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    rd_cmd_t       mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule

// File: rtl/ddr3_axi_rd_checker.sv
// Passive AXI read-channel checker: tracks accepted AR bursts, regenerates the
// address-derived pattern for each R beat and accumulates debug counters/flags.
module ddr3_axi_rd_checker
    import ddr3_test_pkg::*;
#(
    parameter int          CTRL_ADDR_WIDTH = CMD_ADDR_W,
    parameter int          MEM_DQ_WIDTH    = DEF_MEM_DQ_WIDTH,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [31:0] PATTERN_SEED    = 32'h0000_0000,
    parameter int          ERR_CNT_W       = 16
) (
    input  logic                       core_clk,
    input  logic                       core_clk_rst_n,
    input  logic                       i_check_en,
    input  logic                       i_clr,
    input  logic [CTRL_ADDR_WIDTH-1:0] i_m_axi_araddr,
    input  logic [3:0]                 i_m_axi_arlen,
    input  logic                       i_m_axi_arvalid,
    input  logic                       i_m_axi_arready,
    input  logic [MEM_DQ_WIDTH*8-1:0]  i_m_axi_rdata,
    input  logic                       i_m_axi_rlast,
    input  logic                       i_m_axi_rvalid,
    output logic                       o_err_flag,
    output logic [ERR_CNT_W-1:0]       o_err_cnt,
    output logic                       o_len_err,
    output logic                       o_ovf,
    output logic [31:0]                o_beat_cnt,
    output logic [31:0]                o_burst_cnt,
    output logic [CTRL_ADDR_WIDTH-1:0] o_first_err_addr,
    output logic                       o_first_err_vld
);
    localparam int BEAT_W = MEM_DQ_WIDTH * 8;
    localparam int WORDS  = MEM_DQ_WIDTH / 4;

    rd_cmd_t                    push_cmd, head_cmd;
    logic                       q_full, q_empty, q_push, q_pop, q_flush;
    logic [3:0]                 beat_idx_q, beat_idx_d;
    logic [CTRL_ADDR_WIDTH-1:0] head_addr, beat_addr;
    logic [BEAT_W-1:0]          exp_beat;
    logic                       ar_fire, beat_hit, beat_miss, at_last, len_evt;
    logic                       data_err, beat_err;

    logic                       s1_chk_q, s1_miss_q, s1_len_q;
    logic [BEAT_W-1:0]          s1_data_q, s1_exp_q;
    logic [CTRL_ADDR_WIDTH-1:0] s1_addr_q;

    logic                       err_flag_q, err_flag_d;
    logic [ERR_CNT_W-1:0]       err_cnt_q, err_cnt_d;
    logic                       len_err_q, len_err_d;
    logic                       ovf_q, ovf_d;
    logic [31:0]                beat_cnt_q, beat_cnt_d;
    logic [31:0]                burst_cnt_q, burst_cnt_d;
    logic [CTRL_ADDR_WIDTH-1:0] first_addr_q, first_addr_d;
    logic                       first_vld_q, first_vld_d;

    assign push_cmd = '{addr: CMD_ADDR_W'(i_m_axi_araddr), len: i_m_axi_arlen};

    ddr3_rd_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_cmd_fifo (
        .clk_i   (core_clk),
        .rst_ni  (core_clk_rst_n),
        .flush_i (q_flush),
        .push_i  (q_push),
        .din_i   (push_cmd),
        .pop_i   (q_pop),
        .dout_o  (head_cmd),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign ar_fire   = i_check_en && i_m_axi_arvalid && i_m_axi_arready;
    assign q_push    = ar_fire && !q_full;
    assign q_flush   = !i_check_en;
    assign beat_hit  = i_check_en && i_m_axi_rvalid && !q_empty;
    assign beat_miss = i_check_en && i_m_axi_rvalid && q_empty;
    assign at_last   = (beat_idx_q == head_cmd.len);
    // Early rlast and missing rlast both retire the head entry so the next beat resyncs.
    assign q_pop     = beat_hit && (i_m_axi_rlast || at_last);
    assign len_evt   = beat_miss || (beat_hit && (i_m_axi_rlast != at_last));

    assign head_addr = CTRL_ADDR_WIDTH'(head_cmd.addr);
    assign beat_addr = head_addr + CTRL_ADDR_WIDTH'(beat_idx_q) * CTRL_ADDR_WIDTH'(BEAT_ADDR_STEP);

    always_comb begin
        exp_beat = '0;
        for (int k = 0; k < WORDS; k++) begin
            exp_beat[32*k +: 32] = exp_word(PATTERN_SEED, 32'(beat_addr), k);
        end
    end

    always_comb begin
        beat_idx_d = beat_idx_q;
        if (!i_check_en || q_pop) beat_idx_d = '0;
        else if (beat_hit)        beat_idx_d = beat_idx_q + 4'd1;
    end

    assign data_err = s1_chk_q && (s1_data_q != s1_exp_q);
    assign beat_err = data_err || s1_miss_q;

    always_comb begin
        err_flag_d   = err_flag_q;
        err_cnt_d    = err_cnt_q;
        len_err_d    = len_err_q;
        ovf_d        = ovf_q;
        beat_cnt_d   = beat_cnt_q;
        burst_cnt_d  = burst_cnt_q;
        first_addr_d = first_addr_q;
        first_vld_d  = first_vld_q;
        if (beat_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
        if (beat_err || s1_len_q)          err_flag_d = 1'b1;
        if (data_err && !first_vld_q) begin
            first_addr_d = s1_addr_q;
            first_vld_d  = 1'b1;
        end
        if (beat_hit)                             beat_cnt_d  = beat_cnt_q + 32'd1;
        if (beat_hit && i_m_axi_rlast && at_last) burst_cnt_d = burst_cnt_q + 32'd1;
        if (len_evt)                              len_err_d   = 1'b1;
        if (ar_fire && q_full)                    ovf_d       = 1'b1;
        // Clear overrides any update landing in the same cycle, including a stage-2 error.
        if (i_clr) begin
            err_flag_d   = 1'b0;
            err_cnt_d    = '0;
            len_err_d    = 1'b0;
            ovf_d        = 1'b0;
            beat_cnt_d   = '0;
            burst_cnt_d  = '0;
            first_addr_d = '0;
            first_vld_d  = 1'b0;
        end
    end

    always_ff @(posedge core_clk) begin
        if (!core_clk_rst_n) begin
            beat_idx_q   <= '0;
            s1_chk_q     <= 1'b0;
            s1_miss_q    <= 1'b0;
            s1_len_q     <= 1'b0;
            s1_data_q    <= '0;
            s1_exp_q     <= '0;
            s1_addr_q    <= '0;
            err_flag_q   <= 1'b0;
            err_cnt_q    <= '0;
            len_err_q    <= 1'b0;
            ovf_q        <= 1'b0;
            beat_cnt_q   <= '0;
            burst_cnt_q  <= '0;
            first_addr_q <= '0;
            first_vld_q  <= 1'b0;
        end else begin
            beat_idx_q   <= beat_idx_d;
            s1_chk_q     <= beat_hit;
            s1_miss_q    <= beat_miss;
            s1_len_q     <= len_evt;
            if (beat_hit) begin
                s1_data_q <= i_m_axi_rdata;
                s1_exp_q  <= exp_beat;
                s1_addr_q <= beat_addr;
            end
            err_flag_q   <= err_flag_d;
            err_cnt_q    <= err_cnt_d;
            len_err_q    <= len_err_d;
            ovf_q        <= ovf_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_cnt_q  <= burst_cnt_d;
            first_addr_q <= first_addr_d;
            first_vld_q  <= first_vld_d;
        end
    end

    assign o_err_flag       = err_flag_q;
    assign o_err_cnt        = err_cnt_q;
    assign o_len_err        = len_err_q;
    assign o_ovf            = ovf_q;
    assign o_beat_cnt       = beat_cnt_q;
    assign o_burst_cnt      = burst_cnt_q;
    assign o_first_err_addr = first_addr_q;
    assign o_first_err_vld  = first_vld_q;

endmodule
